axi_lite_master: RTL and testbench

//  Single-outstanding AXI4-Lite initiator. Converts simple write/read requests from the

---
 rtl/axi_lite_master.sv | 192 +++++++++++++++++++
 tb/tb_axi_lite_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator with response port and stall timeout
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_RESP,
    S_RD_AR,
    S_RD_DATA,
    S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wvalid;
  logic                  r_bready;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;

  logic w_accept;
  logic w_counting;
  logic w_aw_done;
  logic w_w_done;

  assign w_accept   = (r_state == S_IDLE) && r_req_ready && req_valid;
  assign w_counting = (r_state != S_IDLE) && (r_state != S_RESP);
  // A channel is done once its valid has dropped or is handshaking this cycle.
  assign w_aw_done  = !r_awvalid || awready;
  assign w_w_done   = !r_wvalid || wready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (req_write) begin
              r_awaddr  <= req_addr;
              r_wdata   <= req_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_AW_W;
            end else begin
              r_araddr  <= req_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_AR;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_WR_AW_W: begin
          if (r_awvalid && awready) r_awvalid <= 1'b0;
          if (r_wvalid && wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= bresp;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RD_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_resp  <= rresp;
            r_rsp_rdata <= rdata;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
      logic [CW-1:0] r_cnt;
      logic          r_timeout;

      // Saturating at TMAX guarantees the pulse fires at most once per transaction.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end else begin
          r_timeout <= 1'b0;
          if (w_accept) begin
            r_cnt <= '0;
          end else if (w_counting && (r_cnt != TMAX)) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == TMAX - CW'(1)) r_timeout <= 1'b1;
          end
        end
      end
      assign timeout_err = r_timeout;
    end else begin : g_no_timeout
      assign timeout_err = 1'b0;
    end
  endgenerate

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign awaddr    = r_awaddr;
  assign awvalid   = r_awvalid;
  assign wdata     = r_wdata;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;
  assign araddr    = r_araddr;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - scoreboard bench for axi_lite_master with a delay-programmable responder
module tb_axi_lite_master;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  axi_lite_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .timeout_err(timeout_err),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  int vectors = 0;
  int errors  = 0;
  int to_count = 0;
  logic [33:0] sb[$];

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Responder: each ready/valid is raised once its channel has waited the programmed cycles.
  initial begin
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_dly); w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      if (arvalid) begin arready = (ar_wait >= ar_dly); ar_wait++; end
      else begin arready = 1'b0; ar_wait = 0; end
      if (bready) begin bvalid = (b_wait >= b_dly); bresp = bresp_cfg; b_wait++; end
      else begin bvalid = 1'b0; bresp = 2'b00; b_wait = 0; end
      if (rready) begin rvalid = (r_wait >= r_dly); rdata = rdata_cfg; rresp = rresp_cfg; r_wait++; end
      else begin rvalid = 1'b0; rdata = '0; rresp = 2'b00; r_wait = 0; end
    end
  end

  // Monitor: response scoreboard plus AXI hold and bready exclusivity checks.
  logic        p_aw_pend = 1'b0, p_ar_pend = 1'b0;
  logic [31:0] p_awaddr = '0, p_araddr = '0;
  always @(negedge clk) begin
    logic [33:0] exp;
    if (reset_n) begin
      if (timeout_err) to_count++;
      if (bready) expect_eq("bready_excl", {62'd0, awvalid, wvalid}, 64'd0);
      if (p_aw_pend) expect_eq("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_ar_pend) expect_eq("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          expect_eq("rsp_extra", 64'd1, 64'd0);
        end else begin
          exp = sb.pop_front();
          expect_eq("rsp_rdata", rsp_rdata, exp[33:2]);
          expect_eq("rsp_resp", rsp_resp, exp[1:0]);
        end
      end
      p_aw_pend = awvalid && !awready;
      p_ar_pend = arvalid && !arready;
      p_awaddr  = awaddr;
      p_araddr  = araddr;
    end else begin
      p_aw_pend = 1'b0;
      p_ar_pend = 1'b0;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic [1:0] eresp);
    int n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    expect_eq("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    sb.push_back({er, eresp});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 300) begin @(posedge clk); #1; n++; end
    expect_eq("idle_wait", {63'd0, (n < 300)}, 64'd1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Reset state
    #22;
    expect_eq("rst_req_ready", {63'd0, req_ready}, 64'd0);
    expect_eq("rst_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
    expect_eq("rst_data", {awaddr, wdata} | {araddr, rsp_rdata}, 64'd0);
    expect_eq("rst_resp_to", {61'd0, rsp_resp, timeout_err}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    #1 expect_eq("rel_req_ready_pre", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    expect_eq("rel_req_ready", {63'd0, req_ready}, 64'd1);

    // 1: write, immediate handshakes
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00);
    @(negedge clk);
    expect_eq("t1_awaddr", awaddr, 64'h10);
    expect_eq("t1_wdata", wdata, 64'hDEADBEEF);
    expect_eq("t1_valids", {62'd0, awvalid, wvalid}, 64'd3);
    expect_eq("t1_req_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    wait_idle();

    // 2: awready at +1, wready at +4
    aw_dly = 1; w_dly = 4;
    issue(1'b1, 32'h14, 32'hA5A5_0F0F, 32'h0, 2'b00);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      expect_eq("t2_awvalid", {63'd0, awvalid}, {63'd0, (c <= 1)});
      expect_eq("t2_wvalid", {63'd0, wvalid}, {63'd0, (c <= 4)});
      expect_eq("t2_bready", {63'd0, bready}, {63'd0, (c == 5)});
    end
    @(posedge clk); #1;
    wait_idle();
    aw_dly = 0; w_dly = 0;

    // 3: read, arready at +2, rvalid after 3 cycles of rready
    ar_dly = 2; r_dly = 3; rdata_cfg = 32'h12345678; rresp_cfg = 2'b00;
    issue(1'b0, 32'h20, 32'h0, 32'h12345678, 2'b00);
    @(negedge clk);
    expect_eq("t3_araddr", araddr, 64'h20);
    expect_eq("t3_arvalid", {63'd0, arvalid}, 64'd1);
    @(posedge clk); #1;
    wait_idle();
    ar_dly = 0; r_dly = 0;

    // 4: SLVERR read held in RESP for 5 cycles
    rdata_cfg = 32'hCAFE0001; rresp_cfg = 2'b10; rsp_ready = 1'b0;
    issue(1'b0, 32'h24, 32'h0, 32'hCAFE0001, 2'b10);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    expect_eq("t4_rsp_wait", {63'd0, rsp_valid}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      expect_eq("t4_hold", {28'd0, rsp_valid, rsp_resp, req_ready, rsp_rdata},
                {28'd0, 1'b1, 2'b10, 1'b0, 32'hCAFE0001});
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();
    rresp_cfg = 2'b00;

    // 5: arready withheld, timeout pulse after 8 cycles
    ar_dly = 100000; rdata_cfg = 32'h0000_0055;
    issue(1'b0, 32'h28, 32'h0, 32'h0000_0055, 2'b00);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      expect_eq("t5_timeout", {63'd0, timeout_err}, {63'd0, (c == 8)});
      expect_eq("t5_arvalid", {63'd0, arvalid}, 64'd1);
    end
    @(posedge clk); #1;
    ar_dly = 0;
    wait_idle();
    expect_eq("t5_to_count", to_count, 64'd1);

    // 6: reset while waiting in WR_RESP
    b_dly = 100000;
    issue(1'b1, 32'h30, 32'h1111_2222, 32'h0, 2'b00);
    n = 0;
    @(negedge clk);
    while (!bready && n < 50) begin @(negedge clk); n++; end
    expect_eq("t6_bready_wait", {63'd0, bready}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    expect_eq("t6_rst_drop", {60'd0, bready, rsp_valid, awvalid, req_ready}, 64'd0);
    sb.delete();
    b_dly = 0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    expect_eq("t6_req_ready", {63'd0, req_ready}, 64'd1);

    // 7: DECERR write after recovery, then a back-to-back read
    bresp_cfg = 2'b11; b_dly = 2;
    issue(1'b1, 32'h40, 32'h0BAD_F00D, 32'h0, 2'b11);
    rdata_cfg = 32'h8765_4321; rresp_cfg = 2'b00;
    issue(1'b0, 32'h44, 32'h0, 32'h8765_4321, 2'b00);
    wait_idle();
    expect_eq("end_to_count", to_count, 64'd1);
    expect_eq("end_sb_empty", sb.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
